intr_sched: RTL and testbench

- Synthesizable, parametrised interrupt scheduler and run monitor for core-level simulation and FPGA bring-up.
- Drives NUM_CH interrupt lines (ext_intr, timer_intr, ...) into core, each with a programmable assert window (one-shot or periodic).
- Counts run cycles, latches the cycle at which the core raises completed, and flags a watchdog timeout.
- Sits between the bench/host config interface and core interrupt inputs.

---
 rtl/intr_sched_pkg.sv | 25 ++
 rtl/intr_sched_chan.sv | 65 ++++++
 rtl/intr_sched.sv | 175 +++++++++++++++++
 tb/tb_intr_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_sched_pkg.sv
// Shared types and defaults for the interrupt scheduler / run monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package intr_sched_pkg;

    localparam int DEF_CNT_W      = 32;
    localparam int DEF_MAX_CYCLES = 20000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // Per-channel schedule. Fields are DEF_CNT_W wide; instances with a
    // narrower CNT_W zero-extend on write and use the low CNT_W bits, so
    // CNT_W must not exceed DEF_CNT_W.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] start;
        logic [DEF_CNT_W-1:0] len;
        logic [DEF_CNT_W-1:0] period;
    } chan_cfg_t;

endpackage

// File: rtl/intr_sched_chan.sv
// One interrupt channel: phase counter plus window decision for the next run cycle.
// Latency: intr is registered; it carries the value for the cycle the top counter shows.
// Backpressure: none; advances whenever the top says enter or step, drops to 0 otherwise.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   enter          first RUN cycle is being entered (cyc_nxt == 0)
//   step           RUN continues into cycle cyc_nxt
//   cyc_nxt        run cycle the registered outputs will describe
//   start/len/period  schedule for this channel
//   intr           interrupt line, aligned with the top cycle counter
module intr_sched_chan #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enter,
    input  logic             step,
    input  logic [CNT_W-1:0] cyc_nxt,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] period,
    output logic             intr
);

    logic             act_q;
    logic             act_base;
    logic             act_d;
    logic [CNT_W-1:0] ph_q;
    logic [CNT_W-1:0] ph_d;
    logic             intr_d;

    // The window test uses the phase counter rather than start+len, so a
    // schedule whose end lies past 2**CNT_W never wraps back to low cycles.
    always_comb begin
        // Entering RUN discards whatever phase state the previous run left.
        act_base = enter ? 1'b0 : act_q;
        act_d    = act_base || (cyc_nxt == start);
        ph_d     = '0;
        if (act_base) begin
            if (period != '0) begin
                ph_d = (ph_q == period - 1'b1) ? '0 : ph_q + 1'b1;
            end else begin
                ph_d = (&ph_q) ? ph_q : ph_q + 1'b1;
            end
        end
        // len == 0 can never satisfy ph_d < len, so the channel stays quiet.
        intr_d = act_d && (ph_d < len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= 1'b0;
            ph_q  <= '0;
            intr  <= 1'b0;
        end else if (enter || step) begin
            act_q <= act_d;
            ph_q  <= ph_d;
            intr  <= intr_d;
        end else begin
            intr  <= 1'b0;
        end
    end

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler and run monitor: FSM, run-cycle counter, config file, watchdog.
// Latency: intr_out aligned with cycle; done/timeout one cycle after the deciding RUN cycle.
// Backpressure: none; cfg writes outside IDLE and run pulses while busy are dropped.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   cfg_we/cfg_ch         config write strobe and channel index (IDLE only)
//   cfg_start/len/period  channel schedule fields
//   run                   start pulse (IDLE, DONE or TIMEOUT)
//   core_completed        completion flag from the core, sampled in RUN
//   intr_out              interrupt lines to the core
//   cycle                 current run cycle
//   busy/done/timeout     state decode
//   done_cycle            cycle at which core_completed was sampled high
module intr_sched
    import intr_sched_pkg::*;
#(
    parameter  int NUM_CH     = 2,
    parameter  int CNT_W      = DEF_CNT_W,
    parameter  int MAX_CYCLES = DEF_MAX_CYCLES,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_start,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              run,
    input  logic              core_completed,
    output logic [NUM_CH-1:0] intr_out,
    output logic [CNT_W-1:0]  cycle,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  done_cycle
);

    state_t           state_q;
    state_t           state_d;
    logic             enter_run;
    logic             step_run;
    logic             last_cycle;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] done_cycle_q;
    logic [CNT_W-1:0] cyc_nxt;

    chan_cfg_t        cfg_q [NUM_CH];
    chan_cfg_t        cfg_new;
    logic             cfg_hit;
    logic [NUM_CH-1:0] wr_sel;

    //------------------------------------------------------------------
    // Config register file
    //------------------------------------------------------------------
    assign cfg_hit = cfg_we && (state_q == IDLE) && (int'({1'b0, cfg_ch}) < NUM_CH);

    always_comb begin
        cfg_new        = '0;
        cfg_new.start  = DEF_CNT_W'(cfg_start);
        cfg_new.len    = DEF_CNT_W'(cfg_len);
        cfg_new.period = DEF_CNT_W'(cfg_period);
    end

    always_comb begin
        wr_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_sel[c] = cfg_hit && (cfg_ch == CH_W'(c));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cfg_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_sel[c]) begin
                    cfg_q[c] <= cfg_new;
                end
            end
        end
    end

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    assign last_cycle = (cycle_q == CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        enter_run = 1'b0;
        step_run  = 1'b0;
        case (state_q)
            IDLE, DONE, TIMEOUT: begin
                if (run) begin
                    state_d   = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                // Completion on the watchdog's terminal cycle counts as DONE.
                if (core_completed) begin
                    state_d = DONE;
                end else if (last_cycle) begin
                    state_d = TIMEOUT;
                end else begin
                    step_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cycle_q      <= '0;
            done_cycle_q <= '0;
        end else begin
            state_q <= state_d;
            if (enter_run) begin
                cycle_q      <= '0;
                done_cycle_q <= '0;
            end else begin
                if (step_run) begin
                    cycle_q <= cycle_q + 1'b1;
                end
                if ((state_q == RUN) && core_completed) begin
                    done_cycle_q <= cycle_q;
                end
            end
        end
    end

    // Cycle the channel registers will describe after this edge.
    assign cyc_nxt = enter_run ? '0 : cycle_q + 1'b1;

    //------------------------------------------------------------------
    // Channels
    //------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        chan_cfg_t cfg_eff;

        // A write coinciding with the run pulse must already shape cycle 0,
        // so bypass the register file for the channel being written.
        assign cfg_eff = wr_sel[c] ? cfg_new : cfg_q[c];

        intr_sched_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .enter   (enter_run),
            .step    (step_run),
            .cyc_nxt (cyc_nxt),
            .start   (cfg_eff.start[CNT_W-1:0]),
            .len     (cfg_eff.len[CNT_W-1:0]),
            .period  (cfg_eff.period[CNT_W-1:0]),
            .intr    (intr_out[c])
        );
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign cycle      = cycle_q;
    assign done_cycle = done_cycle_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign timeout    = (state_q == TIMEOUT);

endmodule

// File: tb/tb_intr_sched.sv
module tb_intr_sched;

    localparam int A_MAX = 2000;
    localparam int B_MAX = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_start;
    logic [31:0] cfg_len;
    logic [31:0] cfg_period;
    logic        run;
    logic        cc;

    logic [2:0]  a_intr;
    logic [31:0] a_cycle;
    logic [31:0] a_done_cycle;
    logic        a_busy, a_done, a_timeout;

    logic [0:0]  b_intr;
    logic [15:0] b_cycle;
    logic [15:0] b_done_cycle;
    logic        b_busy, b_done, b_timeout;

    // Three-channel build for schedule tests.
    intr_sched #(
        .NUM_CH     (3),
        .CNT_W      (32),
        .MAX_CYCLES (A_MAX)
    ) u_a (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we & ~sel),
        .cfg_ch         (cfg_ch),
        .cfg_start      (cfg_start),
        .cfg_len        (cfg_len),
        .cfg_period     (cfg_period),
        .run            (run & ~sel),
        .core_completed (cc & ~sel),
        .intr_out       (a_intr),
        .cycle          (a_cycle),
        .busy           (a_busy),
        .done           (a_done),
        .timeout        (a_timeout),
        .done_cycle     (a_done_cycle)
    );

    // Single-channel build with a short watchdog.
    intr_sched #(
        .NUM_CH     (1),
        .CNT_W      (16),
        .MAX_CYCLES (B_MAX)
    ) u_b (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we & sel),
        .cfg_ch         (cfg_ch[0:0]),
        .cfg_start      (cfg_start[15:0]),
        .cfg_len        (cfg_len[15:0]),
        .cfg_period     (cfg_period[15:0]),
        .run            (run & sel),
        .core_completed (cc & sel),
        .intr_out       (b_intr),
        .cycle          (b_cycle),
        .busy           (b_busy),
        .done           (b_done),
        .timeout        (b_timeout),
        .done_cycle     (b_done_cycle)
    );

    logic [2:0]  o_intr;
    logic [31:0] o_cycle;
    logic [31:0] o_done_cycle;
    logic        o_busy, o_done, o_timeout;

    always_comb begin
        if (sel) begin
            o_intr       = {2'b00, b_intr};
            o_cycle      = {16'h0000, b_cycle};
            o_done_cycle = {16'h0000, b_done_cycle};
            o_busy       = b_busy;
            o_done       = b_done;
            o_timeout    = b_timeout;
        end else begin
            o_intr       = a_intr;
            o_cycle      = a_cycle;
            o_done_cycle = a_done_cycle;
            o_busy       = a_busy;
            o_done       = a_done;
            o_timeout    = a_timeout;
        end
    end

    // Reference schedule model and scoreboard.
    int     total = 0;
    int     bad   = 0;
    int     nch;
    longint m_start  [3];
    longint m_len    [3];
    longint m_period [3];

    typedef struct {
        int         n;
        logic [2:0] v;
    } exp_t;

    exp_t sb[$];

    function automatic logic exp_bit(input longint s, input longint l, input longint p, input longint n);
        if (n < s) return 1'b0;
        if (p == 0) return ((n - s) < l);
        return (((n - s) % p) < l);
    endfunction

    function automatic logic [2:0] exp_vec(input int n);
        logic [2:0] v;
        v = '0;
        for (int c = 0; c < nch; c++) begin
            v[c] = exp_bit(m_start[c], m_len[c], m_period[c], longint'(n));
        end
        return v;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 3; c++) begin
            m_start[c]  = 0;
            m_len[c]    = 0;
            m_period[c] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; take = bench expects the write to be accepted
    // (the model still drops out-of-range channels); hold leaves cfg_we up
    // so the write lands with the following run pulse.
    task automatic cfg_write(input int ch, input longint s, input longint l, input longint p,
                             input bit take, input bit hold);
        cfg_ch     = 2'(ch);
        cfg_start  = 32'(s);
        cfg_len    = 32'(l);
        cfg_period = 32'(p);
        cfg_we     = 1'b1;
        if (take && ch < nch) begin
            m_start[ch]  = s;
            m_len[ch]    = l;
            m_period[ch] = p;
        end
        if (!hold) begin
            @(negedge clk);
            cfg_we = 1'b0;
        end
    endtask

    // Called at a negedge. Runs cycles 0..last; completes selects DONE vs
    // watchdog expiry at last. poke_at injects a RUN-time config write and
    // run pulse; rst_at aborts with an asynchronous reset at that cycle.
    task automatic do_run(input int last, input bit completes, input int poke_at, input int rst_at);
        exp_t e;
        for (int n = 0; n <= last; n++) begin
            e.n = n;
            e.v = exp_vec(n);
            sb.push_back(e);
        end
        run = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            run    = 1'b0;
            cfg_we = 1'b0;
            cc     = 1'b0;
            e = sb.pop_front();
            chk($sformatf("cycle@%0d", e.n), 64'(o_cycle), 64'(e.n));
            chk($sformatf("intr@%0d", e.n), 64'(o_intr), 64'(e.v));
            chk($sformatf("busy@%0d", e.n), 64'(o_busy), 64'd1);
            if (e.n == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_intr", 64'(o_intr), 64'd0);
                chk("rst_busy", 64'(o_busy), 64'd0);
                chk("rst_cycle", 64'(o_cycle), 64'd0);
                chk("rst_done", 64'(o_done), 64'd0);
                chk("rst_done_cycle", 64'(o_done_cycle), 64'd0);
                sb.delete();
                @(negedge clk);
                rst = 1'b0;
                clear_model();
                return;
            end
            if (e.n == poke_at) begin
                cfg_ch     = 2'd0;
                cfg_start  = 32'd5;
                cfg_len    = 32'd200;
                cfg_period = 32'd0;
                cfg_we     = 1'b1;
                run        = 1'b1;
            end
            if (e.n == last && completes) cc = 1'b1;
        end
        @(negedge clk);
        run    = 1'b0;
        cfg_we = 1'b0;
        cc     = 1'b0;
        chk("end_busy", 64'(o_busy), 64'd0);
        chk("end_done", 64'(o_done), 64'(completes));
        chk("end_timeout", 64'(o_timeout), 64'(!completes));
        chk("end_intr", 64'(o_intr), 64'd0);
        chk("end_cycle", 64'(o_cycle), 64'(last));
        chk("end_done_cycle", 64'(o_done_cycle), completes ? 64'(last) : 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        sel        = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_start  = '0;
        cfg_len    = '0;
        cfg_period = '0;
        run        = 1'b0;
        cc         = 1'b0;
        nch        = 3;
        clear_model();

        // Reset state on both builds.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_intr", 64'(o_intr), 64'd0);
            chk("reset_cycle", 64'(o_cycle), 64'd0);
            chk("reset_busy", 64'(o_busy), 64'd0);
            chk("reset_done", 64'(o_done), 64'd0);
            chk("reset_timeout", 64'(o_timeout), 64'd0);
            chk("reset_done_cycle", 64'(o_done_cycle), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Watchdog build: len=0 channel plus an out-of-range write.
        sel = 1'b1;
        nch = 1;
        cfg_write(0, 2, 0, 4, 1'b1, 1'b0);
        cfg_write(1, 0, 5, 0, 1'b1, 1'b0);
        do_run(B_MAX - 1, 1'b0, -1, -1);
        repeat (2) @(negedge clk);
        chk("timeout_hold", 64'(o_timeout), 64'd1);
        do_run(B_MAX - 1, 1'b1, -1, -1);

        // Schedule build.
        sel = 1'b0;
        nch = 3;
        clear_model();
        @(negedge clk);
        cfg_write(0, 1000, 200, 0, 1'b1, 1'b0);
        cfg_write(3, 0, 50, 0, 1'b1, 1'b0);
        cfg_write(1, 10, 3, 8, 1'b1, 1'b0);
        cfg_write(2, 10, 8, 8, 1'b1, 1'b1);
        do_run(1500, 1'b1, -1, -1);

        // Write while in DONE is dropped; results hold.
        cfg_write(1, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("done_hold", 64'(o_done), 64'd1);
        chk("done_cycle_hold", 64'(o_done_cycle), 64'd1500);

        // Re-run from DONE with a RUN-time write and run pulse at cycle 3.
        do_run(1300, 1'b1, 3, -1);

        // Reset in the middle of ch0's window, then a run on cleared config.
        do_run(1100, 1'b0, -1, 1100);
        do_run(100, 1'b1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
